// File: rtl/despacho_cajas_pkg.sv
// rtl/despacho_cajas_pkg.sv - shared types and constants for the box dispatch block
// Purpose: FSM state encoding, box type indices and default sizing.
// Ports: none (package).
package despacho_cajas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    CLEAR  = 2'd2,
    DEPART = 2'd3
  } estado_t;

  localparam int TIPO_ALG_BAJO = 0;
  localparam int TIPO_POL_BAJO = 1;
  localparam int TIPO_ACR_BAJO = 2;
  localparam int TIPO_ALG_ALTO = 3;
  localparam int TIPO_ACR_ALTO = 4;

  localparam int N_TIPOS_DEF = 5;
  localparam int CAP_DEF     = 4;
  localparam int TYPE_W_DEF  = 3;

endpackage

// File: rtl/despacho_cajas_if.sv
// rtl/despacho_cajas_if.sv - valid/ready box offer channel towards the truck loader
// Purpose: groups the shipping handshake.
// Signals: ship_valid (box offered), ship_type (type index), ship_ready (loader accepts).
// Modports: master = dispatch side, slave = loader side.
interface despacho_cajas_if
  import despacho_cajas_pkg::*;
#(
  parameter int TYPE_W = TYPE_W_DEF
);

  logic              ship_valid;
  logic              ship_ready;
  logic [TYPE_W-1:0] ship_type;

  modport master (
    output ship_valid,
    output ship_type,
    input  ship_ready
  );

  modport slave (
    input  ship_valid,
    input  ship_type,
    output ship_ready
  );

endinterface

// File: rtl/despacho_cajas_arbitro_rr.sv
// rtl/despacho_cajas_arbitro_rr.sv - combinational round-robin pick among full boxes
// Purpose: returns the first set request searching upward from ptr, wrapping mod N.
// Ports: req (request flags), ptr (search start, < N), gnt_idx (selected index), any (some request set).
module arbitro_rr
  import despacho_cajas_pkg::*;
#(
  parameter int N = N_TIPOS_DEF,
  parameter int W = TYPE_W_DEF
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic [W:0] cand;
  logic       found;

  // One extra bit on cand so ptr+i cannot overflow before the wrap subtraction.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (W+1)'(i);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      if (!found && req[cand[W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[W-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/despacho_cajas.sv
// rtl/despacho_cajas.sv - hands full sock boxes to the truck loader in round-robin order
// Purpose: picks a full box, offers it over valid/ready, clears its counter once
//          accepted, and requests truck departure after CAP boxes.
// Ports: clk, reset (sync, active low), box_full (per-counter full flags),
//        truck_present, ship (offer channel, master), box_clear (one-hot clear pulse),
//        load_count (boxes on current truck), truck_go (depart request), busy (not IDLE).
module despacho_cajas
  import despacho_cajas_pkg::*;
#(
  parameter int N_TIPOS = N_TIPOS_DEF,
  parameter int CAP     = CAP_DEF,
  parameter int TYPE_W  = TYPE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TIPOS-1:0] box_full,
  input  logic               truck_present,
  despacho_cajas_if.master   ship,
  output logic [N_TIPOS-1:0] box_clear,
  output logic [2:0]         load_count,
  output logic               truck_go,
  output logic               busy
);

  estado_t           state_q, state_d;
  logic [TYPE_W-1:0] grant_q, grant_d;
  logic [TYPE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [2:0]        load_q, load_d;

  logic [TYPE_W-1:0] pick_idx;
  logic              pick_any;

  arbitro_rr #(
    .N (N_TIPOS),
    .W (TYPE_W)
  ) u_arbitro (
    .req     (box_full),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      load_q   <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    load_d   = load_q;
    case (state_q)
      IDLE: begin
        if (truck_present && (load_q < 3'(CAP)) && pick_any) begin
          grant_d = pick_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Losing the truck takes priority over a same-cycle accept.
        if (!truck_present) begin
          state_d = IDLE;
        end else if (ship.ship_ready) begin
          state_d  = CLEAR;
          load_d   = load_q + 3'd1;
          rr_ptr_d = (grant_q == TYPE_W'(N_TIPOS - 1)) ? '0 : grant_q + TYPE_W'(1);
        end
      end
      CLEAR: begin
        state_d = (load_q == 3'(CAP)) ? DEPART : IDLE;
      end
      DEPART: begin
        if (!truck_present) begin
          load_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    box_clear = '0;
    if (state_q == CLEAR) begin
      box_clear[grant_q] = 1'b1;
    end
  end

  assign ship.ship_valid = (state_q == OFFER);
  assign ship.ship_type  = grant_q;
  assign load_count      = load_q;
  assign truck_go        = (state_q == DEPART);
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_despacho_cajas.sv
// tb/tb_despacho_cajas.sv - scoreboard bench for despacho_cajas
module tb_despacho_cajas;
  import despacho_cajas_pkg::*;

  localparam int NT   = 5;
  localparam int CAPV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] box_full;
  logic          truck_present;
  logic [NT-1:0] box_clear;
  logic [2:0]    load_count;
  logic          truck_go;
  logic          busy;

  despacho_cajas_if #(.TYPE_W(3)) ship_if ();

  despacho_cajas #(
    .N_TIPOS (NT),
    .CAP     (CAPV),
    .TYPE_W  (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .box_full      (box_full),
    .truck_present (truck_present),
    .ship          (ship_if),
    .box_clear     (box_clear),
    .load_count    (load_count),
    .truck_go      (truck_go),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            exp_q[$];
  int            model_ptr = 0;
  bit            mon_en = 1'b0;
  logic [NT-1:0] clr_seen = '0;

  int            model_load = 0;
  bit            departing  = 1'b0;
  logic [NT-1:0] exp_clr    = '0;
  bit            prev_offer = 1'b0;
  int            prev_type  = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Service order of a batch of flags that only drop when served: set bits in
  // circular order starting at the current round-robin position.
  task automatic push_batch(input logic [NT-1:0] m);
    int k;
    int last;
    last = model_ptr;
    for (int i = 0; i < NT; i++) begin
      k = (model_ptr + i) % NT;
      if (m[k]) begin
        exp_q.push_back(k);
        last = k;
      end
    end
    model_ptr = (last + 1) % NT;
  endtask

  task automatic monitor_cycle();
    logic [NT-1:0] nxt_clr;
    bit            xfer;
    int            et;
    check(box_clear == exp_clr, "box_clear", int'(box_clear), int'(exp_clr));
    check(int'(load_count) == model_load, "load_count", int'(load_count), model_load);
    check(truck_go == departing, "truck_go", int'(truck_go), int'(departing));
    check(int'(load_count) <= CAPV, "load_le_cap", int'(load_count), CAPV);
    if (departing) check(!ship_if.ship_valid, "no_offer_in_depart", int'(ship_if.ship_valid), 0);
    if (prev_offer && ship_if.ship_valid)
      check(int'(ship_if.ship_type) == prev_type, "type_stable", int'(ship_if.ship_type), prev_type);
    nxt_clr = '0;
    xfer = ship_if.ship_valid && ship_if.ship_ready && truck_present && reset;
    if (!reset) begin
      model_load = 0;
      departing  = 1'b0;
      prev_offer = 1'b0;
    end else begin
      if (exp_clr != '0 && model_load == CAPV) departing = 1'b1;
      else if (departing && !truck_present) begin
        departing  = 1'b0;
        model_load = 0;
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_transfer", int'(ship_if.ship_type), -1);
        end else begin
          et = exp_q.pop_front();
          check(int'(ship_if.ship_type) == et, "ship_type", int'(ship_if.ship_type), et);
          nxt_clr = NT'(1) << et;
        end
        model_load++;
      end
      prev_offer = ship_if.ship_valid && !xfer && truck_present;
      prev_type  = int'(ship_if.ship_type);
    end
    exp_clr = nxt_clr;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      clr_seen = box_clear;
      if (mon_en) monitor_cycle();
    end
  end

  // Counter model: a box_clear seen in a cycle drops the flag right after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    box_full = box_full & ~clr_seen;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    truck_present = 1'b0;
    ship_if.ship_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    model_ptr = 0;
  endtask

  task automatic drain(input int budget, input bit rnd, input string name);
    int n;
    n = 0;
    while (!(box_full == '0 && exp_q.size() == 0) && n < budget) begin
      if (rnd) begin
        truck_present      = ($urandom_range(0, 99) < 85);
        ship_if.ship_ready = ($urandom_range(0, 99) < 60);
      end
      step();
      n++;
    end
    check(box_full == '0 && exp_q.size() == 0, name, n, budget);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NT-1:0] mask;
    reset = 1'b0;
    box_full = '0;
    truck_present = 1'b0;
    ship_if.ship_ready = 1'b0;
    step();
    step();
    check(ship_if.ship_valid == 1'b0, "rst_valid", int'(ship_if.ship_valid), 0);
    check(int'(ship_if.ship_type) == 0, "rst_type", int'(ship_if.ship_type), 0);
    check(box_clear == '0, "rst_clear", int'(box_clear), 0);
    check(load_count == 3'd0, "rst_load", int'(load_count), 0);
    check(truck_go == 1'b0, "rst_go", int'(truck_go), 0);
    check(busy == 1'b0, "rst_busy", int'(busy), 0);

    // Single request: offer one cycle after the flag, clear one cycle after accept.
    mon_en = 1'b1;
    reset = 1'b1;
    truck_present = 1'b1;
    ship_if.ship_ready = 1'b1;
    box_full = 5'b00100;
    push_batch(5'b00100);
    step();
    check(ship_if.ship_valid == 1'b1, "single_valid", int'(ship_if.ship_valid), 1);
    check(int'(ship_if.ship_type) == 2, "single_type", int'(ship_if.ship_type), 2);
    step();
    check(box_clear == 5'b00100, "single_clear", int'(box_clear), 4);
    check(load_count == 3'd1, "single_load", int'(load_count), 1);

    // All five full: 0..3 fill the truck, 4 goes on the next truck.
    do_reset();
    truck_present = 1'b1;
    ship_if.ship_ready = 1'b1;
    box_full = 5'b11111;
    push_batch(5'b11111);
    n = 0;
    while (!truck_go && n < 100) begin
      step();
      n++;
    end
    check(truck_go == 1'b1, "rr_truck_go", int'(truck_go), 1);
    check(exp_q.size() == 1, "rr_remaining", exp_q.size(), 1);
    repeat (10) step();
    truck_present = 1'b0;
    step();
    truck_present = 1'b1;
    drain(100, 1'b0, "rr_drain");
    repeat (3) step();

    // Random batches with random truck presence and loader backpressure.
    for (int b = 0; b < 25; b++) begin
      mask = NT'($urandom_range(1, 31));
      push_batch(mask);
      box_full = box_full | mask;
      drain(600, 1'b1, "rand_drain");
    end

    // Backpressure: six held cycles, accept on the seventh.
    do_reset();
    truck_present = 1'b1;
    ship_if.ship_ready = 1'b0;
    box_full = 5'b00010;
    push_batch(5'b00010);
    step();
    for (int i = 0; i < 6; i++) begin
      check(ship_if.ship_valid && ship_if.ship_type == 3'd1, "bp_hold",
            int'(ship_if.ship_valid), 1);
      step();
    end
    ship_if.ship_ready = 1'b1;
    check(ship_if.ship_valid == 1'b1, "bp_valid7", int'(ship_if.ship_valid), 1);
    step();
    check(box_clear == 5'b00010, "bp_clear", int'(box_clear), 2);
    step();

    // Reset during CLEAR: everything back to zero, round-robin restarts at 0.
    box_full = box_full | 5'b00100;
    push_batch(5'b00100);
    step();
    step();
    check(box_clear == 5'b00100, "pre_rst_clear", int'(box_clear), 4);
    reset = 1'b0;
    model_ptr = 0;
    step();
    check(box_clear == '0, "mid_rst_clear", int'(box_clear), 0);
    check(ship_if.ship_valid == 1'b0, "mid_rst_valid", int'(ship_if.ship_valid), 0);
    check(load_count == 3'd0, "mid_rst_load", int'(load_count), 0);
    check(busy == 1'b0, "mid_rst_busy", int'(busy), 0);
    reset = 1'b1;
    box_full = box_full | 5'b10001;
    push_batch(5'b10001);
    drain(100, 1'b0, "post_rst_drain");
    repeat (3) step();

    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/despacho_cajas.md
Name: despacho_cajas

Overview:
- Unloading end of the sock factory line.
- The five pair counters raise a full-box flag at count 7: algodon bajo, polyester bajo, acrilico bajo, algodon alto, acrilico alto.
- This block takes those full boxes in round-robin order, offers each one to the truck loader over a valid/ready handshake, and clears the source counter once the box is accepted.
- When the truck holds CAP boxes it signals departure and waits for a fresh truck.

Parameters:
- N_TIPOS, 5, number of box sources (counters); fixed type map 0=alg bajo, 1=pol bajo, 2=acr bajo, 3=alg alto, 4=acr alto.
- CAP, 4, boxes per truck; legal range 1..7.
- TYPE_W, 3, width of the ship_type code.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- box_full  in  N_TIPOS  full-box flag (CO) per counter; level, stays high until cleared.
- truck_present  in  1  a truck is docked and able to accept boxes.
- ship_ready  in  1  loader accepts the offered box this cycle.
- ship_valid  out  1  a box is being offered.
- ship_type  out  TYPE_W  type index of the offered box (0..4).
- box_clear  out  N_TIPOS  one-hot, one-cycle pulse that resets the served counter.
- load_count  out  3  boxes loaded on the current truck.
- truck_go  out  1  truck full, depart request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, rr_ptr=0, grant=0, load_count=0; all outputs 0.
- States: IDLE, OFFER, CLEAR, DEPART.
- IDLE:
  - If truck_present=1 and load_count<CAP and box_full!=0: select the first set bit searching from rr_ptr upward with wrap mod N_TIPOS.
  - Latch the selection into grant and go to OFFER.
  - Otherwise stay in IDLE.
- OFFER:
  - Outputs: ship_valid=1, ship_type=grant. ship_type must stay stable while ship_valid=1.
  - Cycle with ship_valid=1 and ship_ready=1 is a transfer: go to CLEAR, load_count+1, rr_ptr=(grant+1) mod N_TIPOS.
  - truck_present=0 while not transferring: abort to IDLE. No clear, no count change, rr_ptr unchanged.
  - If truck_present=0 and ship_ready=1 in the same cycle, the abort wins.
- CLEAR:
  - Exactly one cycle with box_clear[grant]=1. box_full is not sampled in this state.
  - Next state is DEPART if load_count==CAP, else IDLE.
  - The counter must drop box_full by the following cycle, so a cleared box is never granted twice.
- DEPART:
  - truck_go=1 held until truck_present==0.
  - On that cycle: load_count=0, truck_go=0, go to IDLE.
  - Loading resumes only after truck_present rises again (checked in IDLE).
- Latency:
  - Full flag to ship_valid: 1 cycle (IDLE to OFFER).
  - Accept to box_clear: 1 cycle.
  - Minimum of 3 cycles per box.
- Boundaries:
  - All five flags set: served 0,1,2,3,4 in that order from rr_ptr=0.
  - A flag rising for an index below rr_ptr waits its turn.
  - CAP=1: DEPART follows every box.
  - load_count never exceeds CAP.
  - A box_full that drops while offered without handshake (external reset of the counter) does not affect the offer; ship_valid stays until accept or truck loss.
  - Reset asserted in any state returns to the reset values on that edge; a pending box_clear is not issued.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, OFFER=2'd1, CLEAR=2'd2, DEPART=2'd3;
  - type index constants TIPO_ALG_BAJO..TIPO_ACR_ALTO (0..4);
  - default N_TIPOS and CAP.
- One sub-module, arbitro_rr: combinational round-robin priority pick.
  - Inputs: req[N_TIPOS-1:0], ptr.
  - Outputs: gnt_idx, any.
  - This keeps the FSM file limited to state, counters and handshake.

Test Plan:
- Reset then single request: reset=0 for 2 cycles, then reset=1, truck_present=1, box_full=5'b00100, ship_ready=1 from OFFER. Required: ship_valid and ship_type=2 one cycle later, box_clear=5'b00100 the next cycle, load_count=1.
- Round robin: box_full=5'b11111 with the counter model clearing on box_clear and ship_ready tied 1. Required: ship_type sequence 0,1,2,3 and truck_go=1 after the 4th clear (CAP=4); after truck_present pulses 0 then 1, the next ship_type=4.
- Backpressure: ship_ready=0 for 6 cycles during OFFER. Required: ship_valid=1 and ship_type constant all 6 cycles, no box_clear, load_count unchanged; accept on cycle 7.
- Truck loss in OFFER: truck_present falls with ship_ready=1 in the same cycle. Required: no box_clear, load_count unchanged, state IDLE, the same type re-offered after truck_present returns.
- Depart hold: load_count reaches 4 with truck_present held 1 for 10 cycles. Required: truck_go=1 all 10 cycles, no ship_valid; load_count=0 the cycle truck_present=0.
- Mid-operation reset: reset=0 during CLEAR. Required: box_clear=0 and all outputs 0 on the next cycle, rr_ptr=0.
